// File: rtl/ser_pkg.sv
// Shared state encoding and bit-order constants for serializer_stream.
package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam logic MSB_FIRST = 1'b0;
   localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable bidirectional shift register; head_c is the next bit to be presented.
// Holds its contents whenever ena is low.
module ser_shift_reg
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data_in,
   input  logic             lsb_first,
   output logic             head_c
);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic             order_q, order_d;

   // Load pre-shifted by one: the first bit leaves through the output flop on the load edge.
   always_comb begin
      sr_d    = sr_q;
      order_d = order_q;
      if (ena && load) begin
         order_d = lsb_first;
         sr_d    = (lsb_first == LSB_FIRST) ? (data_in >> 1) : (data_in << 1);
      end else if (ena && shift) begin
         sr_d    = (order_q == LSB_FIRST) ? (sr_q >> 1) : (sr_q << 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q    <= '0;
         order_q <= MSB_FIRST;
      end else begin
         sr_q    <= sr_d;
         order_q <= order_d;
      end
   end

   assign head_c = (order_q == LSB_FIRST) ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/serializer_stream.sv
// Re-armable parallel-to-serial converter with valid/ready input handshake.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module serializer_stream
   import ser_pkg::*;
#(
   parameter int unsigned MSG_SIZE = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [MSG_SIZE-1:0] iData_in,
   input  logic                iValid,
   input  logic                iLsb_first,
   output logic                oReady,
   output logic                oData_out,
   output logic                oData_flag,
   output logic                oDone,
   output logic                oBusy
);

   localparam int unsigned CNT_W = $clog2(MSG_SIZE + 1);
`ifdef SERIALIZER_PARITY_EN
   localparam int unsigned LAST_CNT = MSG_SIZE;
`else
   localparam int unsigned LAST_CNT = MSG_SIZE - 1;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             data_out_q, data_out_d;
   logic             flag_q, flag_d;
   logic             done_q, done_d;
   logic             accept_c, shift_c, head_c, next_bit_c;

   assign oReady   = (state_q == IDLE);
   assign oBusy    = (state_q != IDLE);
   assign accept_c = ena & iValid & oReady;
   assign shift_c  = ena & (state_q == SHIFT) & (cnt_q != '0);

   ser_shift_reg #(
      .WIDTH(MSG_SIZE)
   ) u_shift_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .load     (accept_c),
      .shift    (shift_c),
      .data_in  (iData_in),
      .lsb_first(iLsb_first),
      .head_c   (head_c)
   );

`ifdef SERIALIZER_PARITY_EN
   logic parity_q, parity_d;

   // Parity is taken from the word as captured, so later input changes cannot affect it.
   always_comb begin
      parity_d = parity_q;
      if (accept_c) parity_d = ^iData_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_q <= 1'b0;
      else        parity_q <= parity_d;
   end

   assign next_bit_c = (cnt_q == CNT_W'(1)) ? parity_q : head_c;
`else
   assign next_bit_c = head_c;
`endif

   // Next-state and output logic; everything holds while ena is low except the done pulse.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;
      flag_d     = flag_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               data_out_d = (iLsb_first == LSB_FIRST) ? iData_in[0] : iData_in[MSG_SIZE-1];
               flag_d     = 1'b1;
               cnt_d      = CNT_W'(LAST_CNT);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (ena) begin
               if (cnt_q != '0) begin
                  data_out_d = next_bit_c;
                  cnt_d      = cnt_q - CNT_W'(1);
               end else begin
                  data_out_d = 1'b0;
                  flag_d     = 1'b0;
                  done_d     = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         data_out_q <= 1'b0;
         flag_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
         flag_q     <= flag_d;
         done_q     <= done_d;
      end
   end

   assign oData_out  = data_out_q;
   assign oData_flag = flag_q;
   assign oDone      = done_q;

endmodule

// File: tb/tb_serializer_stream.sv
// Bench for serializer_stream: directed vector table, multi-cycle corner sequences and
// randomized traffic against a per-cycle stream model. Honours SERIALIZER_PARITY_EN.
module tb_serializer_stream;

   localparam int unsigned MSG = 8;
`ifdef SERIALIZER_PARITY_EN
   localparam int unsigned NB = MSG + 1;
`else
   localparam int unsigned NB = MSG;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           ena = 1'b0;
   logic           iValid = 1'b0;
   logic           iLsb_first = 1'b0;
   logic [MSG-1:0] iData_in = '0;
   logic           oReady, oData_out, oData_flag, oDone, oBusy;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: remaining enabled edges in the current word and its bit stream.
   int            rem = 0;
   logic [NB-1:0] stream_v = '0;
   logic          done_exp = 1'b0;

   typedef struct {
      logic [MSG-1:0] word;
      logic           lsb;
      logic [MSG-1:0] exp_bits;   // presentation order, first bit in [MSG-1]
      logic           exp_par;
   } vec_t;

   vec_t tbl [6];

   serializer_stream #(
      .MSG_SIZE(MSG)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .iData_in  (iData_in),
      .iValid    (iValid),
      .iLsb_first(iLsb_first),
      .oReady    (oReady),
      .oData_out (oData_out),
      .oData_flag(oData_flag),
      .oDone     (oDone),
      .oBusy     (oBusy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [MSG-1:0] w, input logic l);
      iData_in   = w;
      iLsb_first = l;
      iValid     = 1'b1;
      step();
      iValid     = 1'b0;
   endtask

   task automatic wait_idle();
      for (int g = 0; g < 100 && !oReady; g++) step();
      check("drain_to_idle", 32'(oReady), 32'd1);
      step();
   endtask

   // Per-cycle comparison of every output against the stream model.
   task automatic monitor();
      logic           r, e, v, l;
      logic [MSG-1:0] w;
      logic           exp_bit;
      forever begin
         @(posedge clk);
         r = rst_n; e = ena; v = iValid; l = iLsb_first; w = iData_in;
         done_exp = 1'b0;
         if (!r) begin
            rem = 0;
         end else if (e) begin
            if (rem == 0) begin
               if (v) begin
                  for (int i = 0; i < MSG; i++) stream_v[i] = l ? w[i] : w[MSG-1-i];
`ifdef SERIALIZER_PARITY_EN
                  stream_v[MSG] = ^w;
`endif
                  rem = NB;
               end
            end else begin
               if (rem == 1) done_exp = 1'b1;
               rem--;
            end
         end
         #1;
         exp_bit = (rem != 0) ? stream_v[NB-rem] : 1'b0;
         check("cycle_model", 32'({oReady, oBusy, oData_flag, oData_out, oDone}),
               32'({rem == 0, rem != 0, rem != 0, exp_bit, done_exp}));
      end
   endtask

   initial begin
      int flag_cycles;
      int low;

      tbl[0] = '{8'hC1, 1'b0, 8'hC1, 1'b1};
      tbl[1] = '{8'hC1, 1'b1, 8'h83, 1'b1};
      tbl[2] = '{8'h5A, 1'b0, 8'h5A, 1'b0};
      tbl[3] = '{8'h01, 1'b1, 8'h80, 1'b1};
      tbl[4] = '{8'hF0, 1'b1, 8'h0F, 1'b0};
      tbl[5] = '{8'h3C, 1'b1, 8'h3C, 1'b0};

      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({oReady, oBusy, oData_flag, oData_out, oDone}), 32'b10000);
      rst_n = 1'b1;
      @(negedge clk);
      ena = 1'b1;
      step();

      // Directed vector table
      foreach (tbl[k]) begin
         offer(tbl[k].word, tbl[k].lsb);
         for (int i = 0; i < MSG; i++) begin
            check("tbl_bit", 32'({oData_flag, oData_out}), 32'({1'b1, tbl[k].exp_bits[MSG-1-i]}));
            step();
         end
`ifdef SERIALIZER_PARITY_EN
         check("tbl_parity", 32'({oData_flag, oData_out}), 32'({1'b1, tbl[k].exp_par}));
         step();
`endif
         check("tbl_done", 32'({oDone, oData_flag, oReady}), 32'b101);
         step();
         check("tbl_done_clear", 32'(oDone), 32'd0);
      end

      // ena drops for three cycles while the second bit is on the line
      offer(8'hC1, 1'b0);
      flag_cycles = 1;
      step();
      flag_cycles += int'(oData_flag);
      ena = 1'b0;
      repeat (3) begin
         step();
         flag_cycles += int'(oData_flag);
         check("stretch_hold_bit", 32'(oData_out), 32'd1);
      end
      ena = 1'b1;
      for (int g = 0; g < 40 && oData_flag; g++) begin
         step();
         flag_cycles += int'(oData_flag);
      end
      check("stretch_flag_cycles", 32'(flag_cycles), 32'(NB + 3));
      check("stretch_done", 32'(oDone), 32'd1);
      step();

      // iValid held high across two words, inputs change mid-shift
      iData_in = 8'hC1; iLsb_first = 1'b0; iValid = 1'b1;
      step();
      iData_in = 8'h5A; iLsb_first = 1'b1;
      for (int g = 0; g < 40 && oData_flag; g++) step();
      check("b2b_done", 32'(oDone), 32'd1);
      low = 0;
      for (int g = 0; g < 40 && !oData_flag; g++) begin
         low++;
         step();
      end
      check("b2b_gap", 32'(low), 32'd1);
      iValid = 1'b0;
      wait_idle();

      // Asynchronous reset mid-word
      offer(8'hC1, 1'b0);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1 check("async_reset", 32'({oReady, oBusy, oData_flag, oData_out, oDone}), 32'b10000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
      check("after_reset_ready", 32'(oReady), 32'd1);
      offer(8'hA5, 1'b0);
      check("after_reset_first", 32'({oData_flag, oData_out}), 32'b11);
      wait_idle();

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         ena        = ($urandom_range(0, 9) < 8);
         iValid     = ($urandom_range(0, 1) == 1);
         iData_in   = MSG'($urandom);
         iLsb_first = ($urandom_range(0, 1) == 1);
         rst_n      = ($urandom_range(0, 299) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1; ena = 1'b1; iValid = 1'b0;
      step();
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
Parametrised, re-armable parallel-to-serial converter. It is the successor to the one-shot serializer.
- Accepts a MSG_SIZE-bit word via a valid/ready handshake.
- Shifts the word out one bit per enabled clock, MSB-first or LSB-first, selected per word.
- Flags the valid serial window and pulses done at the end.
- Returns to idle for the next word without needing a reset.
- Sits between the message/cipher datapath and the serial output pins.

Parameters:
MSG_SIZE, 64, word width in bits; legal range 2 to 256.
CNT_W, $clog2(MSG_SIZE+1), width of the internal bit counter (derived; must not be overridden).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
ena  input  1  global enable; when low, all state holds.
iData_in  input  MSG_SIZE  parallel word, sampled on the accept cycle.
iValid  input  1  iData_in is offered.
iLsb_first  input  1  bit order for the offered word; 0 = MSB-first, 1 = LSB-first.
oReady  output  1  block can accept a word; combinational, equals (state == IDLE).
oData_out  output  1  serial data bit.
oData_flag  output  1  oData_out carries a valid bit.
oDone  output  1  one-cycle pulse after the last bit.
oBusy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - oData_out, oData_flag and oDone all = 0.
  - Shift register and counter = 0.
  - Reset mid-word abandons the word; nothing resumes after reset releases.
- State IDLE:
  - oReady = 1.
  - Accept happens on a rising edge with ena & iValid & oReady.
  - On accept, capture iData_in and latch iLsb_first.
  - On the same edge, oData_out <= first bit (bit MSG_SIZE-1, or bit 0 if LSB-first) and oData_flag <= 1.
  - Counter <= MSG_SIZE-1; state moves to SHIFT.
- State SHIFT:
  - On each edge with ena high and counter > 0: present the next bit and decrement the counter.
  - On an edge with ena high and counter == 0: oData_out <= 0, oData_flag <= 0, oDone <= 1, state moves to IDLE.
- Timing:
  - oData_flag is high for exactly MSG_SIZE enabled cycles.
  - Latency from the accept edge to the first bit is 0 cycles (registered on the accept edge).
- oDone:
  - Asserted for exactly one clock.
  - Cleared on the next rising edge regardless of ena.
- ena low:
  - State, counter, oData_out and oData_flag hold, so the serial stream stretches.
  - Accept is blocked while ena is low.
- iValid while busy: ignored; oReady = 0 and no capture.
- iData_in and iLsb_first changing during SHIFT: no effect; the word was captured at accept.
- Back-to-back words:
  - The earliest next accept is the edge after oDone rises.
  - This gives exactly one flag-low cycle between words.
- Arithmetic:
  - The counter is unsigned CNT_W bits and never underflows.
  - The counter is compared against 0, not -1.

Optional Feature:
SERIALIZER_PARITY_EN
- Defined: after the last data bit, one extra bit equal to the XOR of the captured word (even parity) is emitted with oData_flag high. The flag window is MSG_SIZE+1 enabled cycles, and oDone follows the parity bit.
- Undefined: no parity logic, and the window is MSG_SIZE cycles.

Decomposition:
- Shared package ser_pkg holds:
  - State encoding localparams: IDLE = 1'b0, SHIFT = 1'b1.
  - The bit-order constants MSB_FIRST = 0, LSB_FIRST = 1.
- One natural sub-module: ser_shift_reg.
  - Loadable bidirectional shift register with hold-on-!ena.
  - Outputs the current head bit.
  - The FSM and counter stay in serializer_stream.

Test Plan:
1. MSG_SIZE=8, ena=1, accept 8'hC1, iLsb_first=0 -> oData_out = 1,1,0,0,0,0,0,1 on 8 consecutive cycles with flag high; oDone one cycle later; oReady back to 1.
2. Accept 8'hC1 with iLsb_first=1 -> 1,0,0,0,0,0,1,1; flag high 8 cycles.
3. Accept 8'hC1 MSB-first, drop ena for 3 cycles after bit 2 -> bit 2 and flag held 4 cycles total; the remaining bits follow unchanged; flag high across 11 cycles.
4. iValid held high with 8'hC1 then 8'h5A -> second accept on the edge after oDone; exactly one flag-low cycle between words; iValid during SHIFT is not captured.
5. Assert rst_n low after bit 4 of 8'hC1 -> all outputs 0 immediately (async); oReady=1 after release; the next word serialises from its first bit.
6. With SERIALIZER_PARITY_EN defined, 8'hC1 MSB-first -> 8 data bits then a parity bit of 1; flag high 9 cycles; oDone on cycle 10.
